// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed signed FIR with one MAC, runtime coefficients, rounding and saturation
module fir_mac_seq #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 8,
    parameter int SHIFT = 4,
    localparam int AW   = $clog2(TAPS),
    localparam int ACCW = DW + CW + $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          sat_flag,
    input  logic          sat_clr
);
    localparam int PW = DW + CW;
    localparam int RW = ACCW + 1;
    localparam logic signed [RW-1:0] RND  = RW'((RW'(1) << SHIFT) >> 1);
    localparam logic signed [RW-1:0] MAXP = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] MINN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [AW:0]          TAPS_V = (AW+1)'(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state, state_nxt;
    logic signed [DW-1:0]   x [TAPS];
    logic signed [CW-1:0]   c [TAPS];
    logic signed [ACCW-1:0] acc;
    logic [AW-1:0]          idx;

    logic                   accept, last_tap, coef_wr;
    logic signed [DW-1:0]   xs;
    logic signed [CW-1:0]   cs;
    logic signed [PW-1:0]   xe, ce, prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [RW-1:0]   acc_ext, rnd_sum, shifted;
    logic                   sat_hi, sat_lo;
    logic [DW-1:0]          scaled;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en;
                if (in_valid)
                    state_nxt = MAC;
            end
            MAC: begin
                if (idx == AW'(TAPS - 1))
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = en;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = (state == IDLE) && in_valid;
    assign last_tap = (state == MAC) && (idx == AW'(TAPS - 1));
    assign coef_wr  = (state == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_V);

    // Full-precision signed product, sign-extended into the accumulator.
    assign xs      = x[idx];
    assign cs      = c[idx];
    assign xe      = {{CW{xs[DW-1]}}, xs};
    assign ce      = {{DW{cs[CW-1]}}, cs};
    assign prod    = xe * ce;
    assign acc_sum = acc + {{(ACCW-PW){prod[PW-1]}}, prod};

    // Round half toward +inf, then clamp to the signed output range.
    assign acc_ext = {acc_sum[ACCW-1], acc_sum};
    assign rnd_sum = acc_ext + RND;
    assign shifted = rnd_sum >>> SHIFT;
    assign sat_hi  = shifted > MAXP;
    assign sat_lo  = shifted < MINN;
    assign scaled  = sat_hi ? MAXP[DW-1:0] : (sat_lo ? MINN[DW-1:0] : shifted[DW-1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc      <= '0;
            idx      <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else if (en) begin
            if (coef_wr)
                c[coef_addr] <= coef_data;
            if (accept) begin
                x[0] <= in_data;
                for (int k = 1; k < TAPS; k++)
                    x[k] <= x[k-1];
                acc <= '0;
                idx <= '0;
            end
            if (state == MAC) begin
                acc <= acc_sum;
                idx <= idx + AW'(1);
            end
            if (last_tap)
                out_data <= scaled;
            if (last_tap && (sat_hi || sat_lo))
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - directed and enable-stress bench for fir_mac_seq
module tb_fir_mac_seq;
    logic        clk, rst, en, in_valid, coef_we, sat_clr;
    logic [15:0] in_data, coef_data;
    logic [2:0]  coef_addr;
    logic        in_ready, out_valid, sat_flag;
    logic [15:0] out_data;
    logic        in_ready6, out_valid6, sat_flag6;
    logic [15:0] out_data6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_out, t_prev;
    logic [15:0] y;
    logic signed [15:0] mx [8];
    int mc [8];

    fir_mac_seq #(.DW(16), .CW(16), .TAPS(8), .SHIFT(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    fir_mac_seq #(.DW(16), .CW(16), .TAPS(6), .SHIFT(4)) u_dut6 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid6), .out_data(out_data6), .sat_flag(sat_flag6), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        step();
        coef_we = 1'b0;
    endtask

    // Sends one sample, waits for its result, checks latency and returns in IDLE.
    task automatic send(input bit sel6, input logic [15:0] d, output logic [15:0] yo);
        int w = 0;
        int lat = 0;
        while (!(sel6 ? in_ready6 : in_ready) && w < 40) begin step(); w++; end
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        while (!(sel6 ? out_valid6 : out_valid) && lat < 40) begin step(); lat++; end
        yo = sel6 ? out_data6 : out_data;
        t_out = cyc;
        chk(sel6 ? "latency6" : "latency", lat, sel6 ? 6 : 8);
        step();
    endtask

    function automatic logic [15:0] model();
        longint s = 0;
        longint r;
        for (int k = 0; k < 8; k++) s += longint'(mx[k]) * longint'(mc[k]);
        r = (s + 8) >>> 4;
        if (r > 32767) return 16'h7fff;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    initial begin
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; sat_clr = 1'b0;
        step(); step();
        rst = 1'b1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_in_ready", in_ready, 1);

        // Impulse response, spacing TAPS+2.
        for (int i = 0; i < 8; i++) wcoef(3'(i), 16'(16 * (i + 1)));
        for (int i = 0; i < 9; i++) begin
            send(1'b0, (i == 0) ? 16'd1 : 16'd0, y);
            chk("impulse", y, (i < 8) ? i + 1 : 0);
            if (i > 0) chk("spacing", t_out - t_prev, 10);
            t_prev = t_out;
        end

        // Rounding half toward +inf.
        do_reset();
        wcoef(3'd0, 16'd1);
        send(1'b0, 16'd8, y);       chk("round_8", y, 16'd1);
        send(1'b0, 16'd7, y);       chk("round_7", y, 16'd0);
        send(1'b0, 16'hfff8, y);    chk("round_m8", y, 16'd0);
        send(1'b0, 16'hfff7, y);    chk("round_m9", y, 16'hffff);
        chk("round_nosat", sat_flag, 0);

        // Saturation and sticky flag.
        do_reset();
        wcoef(3'd0, 16'h7fff);
        send(1'b0, 16'h7fff, y);    chk("sat_pos", y, 16'h7fff);
        chk("sat_flag_pos", sat_flag, 1);
        send(1'b0, 16'h8000, y);    chk("sat_neg", y, 16'h8000);
        sat_clr = 1'b1; step(); sat_clr = 1'b0;
        chk("sat_clr", sat_flag, 0);
        in_valid = 1'b1; in_data = 16'h7fff;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
        chk("sat_set_valid", out_valid, 1);
        step();

        // Coefficient writes: dropped during MAC, applied in IDLE and on the accept edge.
        do_reset();
        wcoef(3'd0, 16'd1);
        send(1'b0, 16'd16, y);      chk("coef_base", y, 16'd1);
        in_valid = 1'b1; in_data = 16'd16;
        step();
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd256;
        step();
        coef_we = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) step();
        chk("coef_mac_drop", {out_valid, out_data}, {1'b1, 16'd1});
        step();
        wcoef(3'd0, 16'd2);
        send(1'b0, 16'd16, y);      chk("coef_idle", y, 16'd2);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd3;
        send(1'b0, 16'd16, y);
        coef_we = 1'b0;
        chk("coef_same_edge", y, 16'd3);

        // Out-of-range address on a 6-tap instance.
        do_reset();
        wcoef(3'd0, 16'd16);
        wcoef(3'd6, 16'd256);
        wcoef(3'd7, 16'd256);
        send(1'b1, 16'd1, y);       chk("t6_first", y, 16'd1);
        for (int i = 1; i < 7; i++) begin
            send(1'b1, 16'd0, y);
            chk("t6_oor", y, 16'd0);
        end

        // Continuous valid with random enable against a reference model.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            mc[k] = int'($urandom_range(0, 400)) - 200;
            mx[k] = '0;
            wcoef(3'(k), 16'(mc[k]));
        end
        begin
            int accepts = 0;
            int outs = 0;
            int edges = 0;
            int en0 = 0;
            bit pending = 0;
            bit acc_edge, en_edge;
            logic [15:0] exp_y = '0;
            in_data = 16'($urandom);
            for (int n = 0; n < 400; n++) begin
                in_valid = (n < 340);
                en = (n >= 340) || ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid) begin
                    chk("rnd_pending", pending, 1);
                    chk("rnd_data", out_data, exp_y);
                    chk("rnd_stretch", edges, 8 + en0);
                    pending = 0;
                    outs++;
                end
                acc_edge = in_ready && in_valid;
                en_edge = en;
                if (acc_edge) begin
                    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
                    mx[0] = in_data;
                    exp_y = model();
                    pending = 1; edges = 0; en0 = 0;
                    accepts++;
                end
                step();
                if (acc_edge) in_data = 16'($urandom);
                else if (pending) begin
                    edges++;
                    if (!en_edge) en0++;
                end
            end
            chk("rnd_count", outs, accepts);
            chk("rnd_some", accepts > 10, 1);
        end
        en = 1'b1;

        // Reset in the middle of MAC.
        do_reset();
        wcoef(3'd0, 16'd16);
        in_valid = 1'b1; in_data = 16'd5;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rstmac_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            chk("rstmac_no_valid", {out_valid, out_data}, 0);
            step();
        end
        send(1'b0, 16'd1, y);       chk("rstmac_coef0", y, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, time-multiplexed FIR filter: one signed multiply-accumulate unit iterates over a `TAPS`-deep delay line and a register-file of runtime-writable coefficients. Replaces the fixed 4-tap, fully parallel, unsigned filter in the sensor signal path. Adds a valid/ready input handshake, an output valid strobe, round-half-up scaling and signed saturation.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `CW`, 16: coefficient width, signed.
- `TAPS`, 8: filter length, ≥2.
- `SHIFT`, 4: output right-shift, 0..DW+CW-1.
- `AW`, `$clog2(TAPS)`: coefficient address width (localparam).
- `ACCW`, `DW+CW+$clog2(TAPS)`: accumulator width (localparam).

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: global enable. When low, all state freezes.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a sample.
- `in_data` in DW: input sample, signed.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in AW: coefficient index.
- `coef_data` in CW: coefficient value, signed.
- `out_valid` out 1: one-cycle strobe, `out_data` is new.
- `out_data` out DW: filtered sample, signed. Held between strobes.
- `sat_flag` out 1: sticky. Set when saturation has occurred.
- `sat_clr` in 1: clears `sat_flag`.

## Operation
- Reset (`rst`=0 at an edge):
  - delay line `x[0..TAPS-1]`, all coefficients `c[0..TAPS-1]`, and the accumulator are set to 0.
  - State goes to IDLE.
  - `out_data`=0, `out_valid`=0, `sat_flag`=0.
  - Reset overrides everything, including mid-MAC. A partial result is discarded and no `out_valid` is produced.
- FSM states: IDLE, MAC, OUT.
  - IDLE: `in_ready`=`en`. Accept on `in_valid && in_ready`:
    - `x[0]<=in_data`, `x[k]<=x[k-1]`;
    - acc<=0, tap index i<=0;
    - go to MAC.
  - MAC: each enabled cycle, `acc <= acc + x[i]*c[i]` (full-precision signed product, sign-extended to ACCW), then i<=i+1.
    - After i=TAPS-1 is accumulated, go to OUT.
    - MAC lasts exactly TAPS enabled cycles.
  - OUT:
    - `out_valid` = (state==OUT) && `en`.
    - `out_data` is registered on the cycle MAC exits. It is visible throughout OUT and held afterwards.
    - Next state: IDLE.
- Scaling of the final acc:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift (round half toward +inf).
  - If r > 2^(DW-1)-1, `out_data` = max positive. If r < -2^(DW-1), `out_data` = min negative. Otherwise `out_data` = r[DW-1:0].
  - Any clamp sets `sat_flag` in the same edge that loads `out_data`.
- `sat_flag`: set has priority over `sat_clr` when both occur on the same edge.
- Coefficient writes:
  - Applied only in IDLE with `en`=1 and `coef_addr` < TAPS.
  - Writes are silently dropped in MAC/OUT, with `en`=0, or for an out-of-range address.
  - A write and a sample accept on the same IDLE edge: the new coefficient is used for that sample.
- `en`=0: FSM, tap index, acc, delay line, coefficients and `sat_flag` hold. `in_ready`=0, `out_valid`=0. `out_data` holds.

## Timing
- Sample accepted at edge T. MAC occupies cycles T..T+TAPS-1. `out_data` is updated at edge T+TAPS. `out_valid`=1 during cycle T+TAPS (state OUT). The block is back in IDLE after edge T+TAPS+1.
- Latency from accept to `out_valid`: TAPS cycles. Minimum sample period: TAPS+2 cycles.
- `en` low stretches each phase cycle-for-cycle. No cycle is lost or duplicated.
- `in_ready` depends only on state and `en`, never on `in_valid`.

## Test plan
- Impulse response. TAPS=8, SHIFT=4, c[i]=16·(i+1). Feed 1 followed by eight 0s. Expect `out_data` 1,2,3,4,5,6,7,8,0, one `out_valid` per sample, spacing TAPS+2=10 cycles.
- Rounding. c[0]=1, others 0, SHIFT=4. Inputs 8, 7, -8, -9 produce outputs 1, 0, 0, -1.
- Saturation.
  - c[0]=0x7FFF, input 0x7FFF: `out_data`=0x7FFF, `sat_flag`=1.
  - Input 0x8000: `out_data`=0x8000.
  - Pulse `sat_clr`: `sat_flag` drops.
  - `sat_clr` on the same edge as a new saturation: `sat_flag` stays 1.
- Handshake and enable. Hold `in_valid`=1 continuously and accept only when `in_ready`=1. Toggle `en` randomly. Compare against a golden model. Expect no dropped or duplicated samples, and the period stretched exactly by the number of `en`=0 cycles.
- Coefficient writes.
  - A write to c[0] during MAC is ignored: the next output matches the old coefficient.
  - A write in IDLE takes effect.
  - A write to address ≥ TAPS (TAPS=6) is ignored.
- Reset mid-MAC. Assert `rst`=0 at cycle T+3. Expect no `out_valid`, `out_data`=0, coefficients=0 (an impulse then yields 0), and `in_ready`=1 on the cycle after reset releases.
